chip_6502_seq: RTL and testbench

CHIP_6502_SEQ -- requirements
Module: chip_6502_seq

---
 rtl/chip_6502_pkg.sv | 22 ++
 rtl/chip_6502_phase_cnt.sv | 39 +++
 rtl/chip_6502_seq.sv | 198 +++++++++++++++++++
 tb/tb_chip_6502_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/chip_6502_pkg.sv
// chip_6502_pkg: shared FSM encoding and defaults for the 6502 sequencer.
// No ports; imported by chip_6502_seq and chip_6502_phase_cnt.
package chip_6502_pkg;

    // Sequencer states; phi is high only in PH2 and WR_WAIT.
    typedef enum logic [2:0] {
        IDLE,
        PH1,
        RD_WAIT,
        PH2,
        WR_WAIT
    } state_e;

    localparam int SETTLE_DEF       = 16;
    localparam int RESET_CYCLES_DEF = 8;
    localparam int PHASE_W          = 8;

    function automatic logic phi_high(input state_e s);
        return (s == PH2) || (s == WR_WAIT);
    endfunction

endpackage

// File: rtl/chip_6502_phase_cnt.sv
// chip_6502_phase_cnt: loadable half-phase down-counter with terminal pulse.
// Ports: clk_i, rst_i (async high), load_i/load_val_i, en_i, tc_o.
module chip_6502_phase_cnt
    import chip_6502_pkg::*;
#(
    parameter int W = PHASE_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Pulses in the last cycle of an enabled half-phase.
    assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/chip_6502_seq.sv
// chip_6502_seq: phi/reset/memory sequencer wrapped around a 6502 core.
// Ports: clk, rst, run -> phi, cpu_res; core bus cpu_ab/rw/dbo -> cpu_dbi;
// memory req/ack handshake mem_*; cycle_cnt counts completed phi cycles.
// Option: define CHIP_6502_SINGLE_STEP_EN to add a step input.
module chip_6502_seq
    import chip_6502_pkg::*;
#(
    parameter int SETTLE       = SETTLE_DEF,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
`ifdef CHIP_6502_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        phi,
    output logic        cpu_res,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_dbo,
    output logic [7:0]  cpu_dbi,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] cycle_cnt
);

    localparam logic [PHASE_W-1:0] LOAD_VAL = PHASE_W'(SETTLE - 1);

    state_e      state_q, state_d;
    logic        phi_q, phi_d;
    logic        res_q, res_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  dbi_q, dbi_d;
    logic [31:0] cnt_q, cnt_d;

    logic        ph_load;
    logic        ph_en;
    logic        ph_tc;
    logic        start_ok;
    logic        cyc_end;
    logic        ack_ok;

`ifdef CHIP_6502_SINGLE_STEP_EN
    logic        step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign start_ok = run && step && !step_q;
`else
    assign start_ok = run;
`endif

    // An ack only counts while a request is actually outstanding.
    assign ack_ok = mem_ack && req_q;
    assign ph_en  = (state_q == PH1) || (state_q == PH2);

    chip_6502_phase_cnt #(
        .W (PHASE_W)
    ) u_phase_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (ph_load),
        .en_i       (ph_en),
        .load_val_i (LOAD_VAL),
        .tc_o       (ph_tc)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dbi_d   = dbi_q;
        cnt_d   = cnt_q;
        ph_load = 1'b0;
        cyc_end = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = PH1;
                    ph_load = 1'b1;
                end
            end
            PH1: begin
                if (ph_tc) begin
                    if (cpu_rw) begin
                        addr_d  = cpu_ab;
                        we_d    = 1'b0;
                        req_d   = 1'b1;
                        state_d = RD_WAIT;
                    end else begin
                        state_d = PH2;
                        ph_load = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (ack_ok) begin
                    dbi_d   = mem_rdata;
                    req_d   = 1'b0;
                    state_d = PH2;
                    ph_load = 1'b1;
                end
            end
            PH2: begin
                if (ph_tc) begin
                    if (!cpu_rw) begin
                        addr_d  = cpu_ab;
                        wdata_d = cpu_dbo;
                        we_d    = 1'b1;
                        req_d   = 1'b1;
                        state_d = WR_WAIT;
                    end else begin
                        cyc_end = 1'b1;
                    end
                end
            end
            WR_WAIT: begin
                if (ack_ok) begin
                    req_d   = 1'b0;
                    cyc_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cyc_end) begin
            cnt_d = cnt_q + 32'd1;
            // Sticky: counter wrap must never re-assert core reset.
            if (cnt_q + 32'd1 == 32'(RESET_CYCLES)) begin
                res_d = 1'b1;
            end
`ifdef CHIP_6502_SINGLE_STEP_EN
            state_d = IDLE;
`else
            if (run) begin
                state_d = PH1;
                ph_load = 1'b1;
            end else begin
                state_d = IDLE;
            end
`endif
        end

        phi_d = phi_high(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phi_q   <= 1'b0;
            res_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dbi_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phi_q   <= phi_d;
            res_q   <= res_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dbi_q   <= dbi_d;
            cnt_q   <= cnt_d;
        end
    end

    assign phi       = phi_q;
    assign cpu_res   = res_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_dbi   = dbi_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_chip_6502_seq.sv
// tb_chip_6502_seq: directed self-checking bench for chip_6502_seq.
// Runs with SETTLE=4, RESET_CYCLES=8.
module tb_chip_6502_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        step;
    logic        phi;
    logic        cpu_res;
    logic [15:0] cpu_ab;
    logic        cpu_rw;
    logic [7:0]  cpu_dbo;
    logic [7:0]  cpu_dbi;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [31:0] cycle_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    chip_6502_seq #(
        .SETTLE       (4),
        .RESET_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
`ifdef CHIP_6502_SINGLE_STEP_EN
        .step      (step),
`endif
        .phi       (phi),
        .cpu_res   (cpu_res),
        .cpu_ab    (cpu_ab),
        .cpu_rw    (cpu_rw),
        .cpu_dbo   (cpu_dbo),
        .cpu_dbi   (cpu_dbi),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .cycle_cnt (cycle_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_seen"}, 32'(mem_req), 32'd1);
    endtask

    task automatic measure_phi(output int hi, output int lo);
        int g;
        g = 0;
        while (phi !== 1'b0 && g < 60) begin @(negedge clk); g++; end
        while (phi !== 1'b1 && g < 60) begin @(negedge clk); g++; end
        hi = 0;
        while (phi === 1'b1 && g < 60) begin
            hi++; g++; @(negedge clk);
        end
        lo = 0;
        while (phi === 1'b0 && g < 60) begin
            lo++; g++; @(negedge clk);
        end
    endtask

    initial begin
        int hi, lo, g;
        logic r7, r8, seen7, seen8, stable, dbi_ok;
        logic [31:0] c0;

        rst = 1'b1; run = 1'b0; step = 1'b0;
        cpu_ab = 16'h0000; cpu_rw = 1'b1; cpu_dbo = 8'h00;
        mem_rdata = 8'h11; mem_ack = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_phi", 32'(phi), 32'd0);
        chk("rst_res", 32'(cpu_res), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_dbi", 32'(cpu_dbi), 32'd0);
        chk("rst_cnt", cycle_cnt, 32'd0);

        // Reset release: cpu_res must rise together with cycle_cnt == 8.
        rst = 1'b0; run = 1'b1;
        seen7 = 1'b0; seen8 = 1'b0; r7 = 1'b1; r8 = 1'b0;
        for (int i = 0; i < 200 && !seen8; i++) begin
            @(negedge clk);
            if (cycle_cnt == 32'd7 && !seen7) begin
                seen7 = 1'b1; r7 = cpu_res;
            end
            if (cycle_cnt == 32'd8) begin
                seen8 = 1'b1; r8 = cpu_res;
            end
        end
        chk("res_at_cnt7", 32'(r7), 32'd0);
        chk("res_at_cnt8", 32'(r8), 32'd1);

        // Ack tied high, reads: 4 high, 4 + 1 wait low.
        measure_phi(hi, lo);
        chk("phi_hi_rd", 32'(hi), 32'd4);
        chk("phi_lo_rd", 32'(lo), 32'd5);
        chk("dbi_tied", 32'(cpu_dbi), 32'h11);

        // Read with ack after 2 clk; now in PH2 of a read.
        mem_ack = 1'b0; mem_rdata = 8'h4C; cpu_ab = 16'h1234;
        wait_req("rd");
        chk("rd_we", 32'(mem_we), 32'd0);
        chk("rd_addr", 32'(mem_addr), 32'h1234);
        stable = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || phi !== 1'b0) stable = 1'b0;
        end
        chk("rd_wait_hold", 32'(stable), 32'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rd_req_drop", 32'(mem_req), 32'd0);
        chk("rd_dbi", 32'(cpu_dbi), 32'h4C);
        chk("rd_phi_up", 32'(phi), 32'd1);

        // Wait for next PH1, then present a write; dbi must not move.
        g = 0; dbi_ok = 1'b1;
        while (phi !== 1'b0 && g < 60) begin
            @(negedge clk); g++;
            if (cpu_dbi !== 8'h4C) dbi_ok = 1'b0;
        end
        cpu_rw = 1'b0; cpu_ab = 16'h0200; cpu_dbo = 8'hA5;
        mem_rdata = 8'hEE;
        g = 0;
        while (mem_req !== 1'b1 && g < 60) begin
            @(negedge clk); g++;
            if (cpu_dbi !== 8'h4C) dbi_ok = 1'b0;
        end
        chk("wr_req_seen", 32'(mem_req), 32'd1);
        c0 = cycle_cnt;
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'h0200);
        chk("wr_wdata", 32'(mem_wdata), 32'hA5);
        chk("wr_phi", 32'(phi), 32'd1);
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || phi !== 1'b1 ||
                mem_addr !== 16'h0200 || mem_wdata !== 8'hA5)
                stable = 1'b0;
            if (cpu_dbi !== 8'h4C) dbi_ok = 1'b0;
        end
        chk("wr_hold", 32'(stable), 32'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("wr_req_drop", 32'(mem_req), 32'd0);
        chk("wr_phi_fall", 32'(phi), 32'd0);
        chk("wr_cnt", cycle_cnt, c0 + 32'd1);
        chk("wr_dbi_kept", 32'({dbi_ok, cpu_dbi}), 32'h14C);

        // Drain to IDLE with reads.
        cpu_rw = 1'b1; mem_ack = 1'b1; run = 1'b0;
        repeat (30) @(negedge clk);

        // run dropped mid-PH1: one full cycle still completes.
        c0 = cycle_cnt;
        run = 1'b1;
        repeat (2) @(negedge clk);
        run = 1'b0;
        hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (phi === 1'b1) hi++;
        end
        chk("drop_phi_hi", 32'(hi), 32'd4);
        chk("drop_cnt", cycle_cnt, c0 + 32'd1);
        chk("drop_phi_end", 32'(phi), 32'd0);

        // rst pulsed during RD_WAIT, then a stray ack.
        mem_ack = 1'b0; run = 1'b1; cpu_ab = 16'h3456;
        wait_req("rst_rd");
        run = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async_req", 32'(mem_req), 32'd0);
        chk("rst_async_res", 32'(cpu_res), 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_req", 32'(mem_req), 32'd0);
        chk("post_rst_dbi", 32'(cpu_dbi), 32'd0);
        chk("post_rst_phi", 32'(phi), 32'd0);
        chk("post_rst_addr", 32'(mem_addr), 32'd0);
        chk("post_rst_cnt", cycle_cnt, 32'd0);
        chk("post_rst_we", 32'(mem_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
